// File: rtl/multi_slot_flits_buffer.sv
// Purpose: NoC ingress buffer that holds up to N_SLOTS complete packets in a slot ring and checks flit sequencing.
// Latency: a closed packet shows on out_link_o the cycle after its TAIL/HEAD_TAIL; credit/free/err pulses are registered (+1 cycle).
// Backpressure: never stalls the link; upstream spends packet tokens, free_signal_o returns one per granted packet.
module multi_slot_flits_buffer #(
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGTH = 4,
  parameter int N_SLOTS           = 2,
  parameter int LW                = $clog2(MAX_PACKET_LENGTH + 1),
  parameter int SW                = $clog2(N_SLOTS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [FLIT_WIDTH-1:0]                 in_link_i,
  input  logic                                  is_valid_i,
  output logic                                  credit_signal_o,
  output logic                                  free_signal_o,
  output logic                                  err_o,
  output logic                                  r_pkt_to_msg_o,
  input  logic                                  g_pkt_to_msg_i,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] out_link_o,
  output logic [LW-1:0]                         out_len_o,
  output logic [SW-1:0]                         pkt_count_o
);

  // Slot pointer width; kept at least 1 bit so a single-slot ring still has a legal index
  localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int FW = (MAX_PACKET_LENGTH > 1) ? $clog2(MAX_PACKET_LENGTH) : 1;

  localparam logic [1:0] TYPE_HEAD      = 2'b00;
  localparam logic [1:0] TYPE_BODY      = 2'b01;
  localparam logic [1:0] TYPE_TAIL      = 2'b10;
  localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_RECEIVING = 2'b01;
  localparam logic [1:0] ST_DROP      = 2'b10;

  localparam logic [PW-1:0] LAST_SLOT = PW'(N_SLOTS - 1);
  localparam logic [LW-1:0] BODY_LIM  = LW'(MAX_PACKET_LENGTH - 1);
  localparam logic [SW-1:0] SLOTS_MAX = SW'(N_SLOTS);

  // Packet storage: not reset, validity is tracked by pkt_count and slot_len
  logic [FLIT_WIDTH-1:0] mem [N_SLOTS][MAX_PACKET_LENGTH];
  logic [LW-1:0]         slot_len [N_SLOTS];

  logic [1:0]    state, state_n;
  logic [LW-1:0] fill, fill_n;
  logic [PW-1:0] wr_slot, rd_slot;
  logic [SW-1:0] pkt_count, pkt_count_n;

  logic          store;
  logic [FW-1:0] store_idx;
  logic          close;
  logic [LW-1:0] close_len;
  logic          err_n;
  logic          grant;
  logic          slot_free;
  logic [1:0]    flit_type;

  assign flit_type = in_link_i[FLIT_WIDTH-1 -: 2];
  assign grant     = g_pkt_to_msg_i && (pkt_count != '0);
  // A head flit is always seen in IDLE, where no slot closes in the same cycle,
  // so the held count alone decides whether a slot can be opened.
  assign slot_free = (pkt_count < SLOTS_MAX);

  // Rx sequencing: decide store/close/error and the next FSM state for the incoming flit
  always_comb begin
    state_n   = state;
    fill_n    = fill;
    store     = 1'b0;
    store_idx = fill[FW-1:0];
    close     = 1'b0;
    close_len = '0;
    err_n     = 1'b0;
    if (is_valid_i) begin
      case (state)
        ST_IDLE: begin
          case (flit_type)
            TYPE_HEAD_TAIL: begin
              if (slot_free) begin
                store     = 1'b1;
                store_idx = '0;
                close     = 1'b1;
                close_len = LW'(1);
              end else begin
                err_n = 1'b1;
              end
            end
            TYPE_HEAD: begin
              if (slot_free) begin
                store     = 1'b1;
                store_idx = '0;
                fill_n    = LW'(1);
                state_n   = ST_RECEIVING;
              end else begin
                err_n   = 1'b1;
                state_n = ST_DROP;
              end
            end
            default: err_n = 1'b1;
          endcase
        end
        ST_RECEIVING: begin
          case (flit_type)
            TYPE_BODY: begin
              // Keep room for the TAIL; a body that would fill the slot is an overrun
              if (fill < BODY_LIM) begin
                store  = 1'b1;
                fill_n = fill + LW'(1);
              end else begin
                err_n   = 1'b1;
                fill_n  = '0;
                state_n = ST_DROP;
              end
            end
            TYPE_TAIL: begin
              store     = 1'b1;
              close     = 1'b1;
              close_len = fill + LW'(1);
              fill_n    = '0;
              state_n   = ST_IDLE;
            end
            default: begin
              err_n   = 1'b1;
              fill_n  = '0;
              state_n = ST_IDLE;
            end
          endcase
        end
        ST_DROP: begin
          case (flit_type)
            TYPE_TAIL:                 state_n = ST_IDLE;
            TYPE_HEAD, TYPE_HEAD_TAIL: err_n   = 1'b1;
            default:                   ;
          endcase
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Held-packet count: a close and a grant in the same cycle cancel out
  always_comb begin
    pkt_count_n = pkt_count;
    case ({close, grant})
      2'b10:   pkt_count_n = pkt_count + SW'(1);
      2'b01:   pkt_count_n = pkt_count - SW'(1);
      default: pkt_count_n = pkt_count;
    endcase
  end

  // Control state, ring pointers and registered pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      fill            <= '0;
      wr_slot         <= '0;
      rd_slot         <= '0;
      pkt_count       <= '0;
      credit_signal_o <= 1'b0;
      free_signal_o   <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      state           <= state_n;
      fill            <= fill_n;
      pkt_count       <= pkt_count_n;
      credit_signal_o <= is_valid_i;
      free_signal_o   <= grant;
      err_o           <= err_n;
      if (close) begin
        wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + PW'(1);
      end
      if (grant) begin
        rd_slot <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + PW'(1);
      end
    end
  end

  // Flit and length storage for the slot currently being written
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_slot][store_idx] <= in_link_i;
    end
    if (close) begin
      slot_len[wr_slot] <= close_len;
    end
  end

  // Present the oldest held packet, head flit at index 0
  always_comb begin
    out_link_o = '0;
    for (int i = 0; i < MAX_PACKET_LENGTH; i++) begin
      out_link_o[i*FLIT_WIDTH +: FLIT_WIDTH] = mem[rd_slot][i];
    end
  end

  assign r_pkt_to_msg_o = (pkt_count != '0);
  assign out_len_o      = r_pkt_to_msg_o ? slot_len[rd_slot] : '0;
  assign pkt_count_o    = pkt_count;

endmodule

// File: tb/tb_multi_slot_flits_buffer.sv
// Purpose: bench for multi_slot_flits_buffer; drives flit sequences and scoreboards granted packets.
// Latency: inputs driven on the falling edge, pulses sampled 1 time unit after the rising edge.
// Backpressure: grants are issued explicitly by the stimulus steps.
module tb_multi_slot_flits_buffer;

  localparam logic [1:0] HD = 2'b00;
  localparam logic [1:0] BD = 2'b01;
  localparam logic [1:0] TL = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  typedef struct packed {
    logic [2:0]   len;
    logic [127:0] dat;
  } pkt_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_link;
  logic         is_valid;
  logic         credit;
  logic         free;
  logic         err;
  logic         r_pkt;
  logic         gnt;
  logic [127:0] out_link;
  logic [2:0]   out_len;
  logic [1:0]   pkt_count;

  int checks = 0;
  int errors = 0;
  int ncred  = 0;
  int nerr   = 0;
  int nfree  = 0;
  logic last_err;
  logic last_free;

  pkt_t         sbq[$];
  logic [127:0] acc;
  int           acc_n;

  multi_slot_flits_buffer #(
    .FLIT_WIDTH(32),
    .MAX_PACKET_LENGTH(4),
    .N_SLOTS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_link_i(in_link),
    .is_valid_i(is_valid),
    .credit_signal_o(credit),
    .free_signal_o(free),
    .err_o(err),
    .r_pkt_to_msg_o(r_pkt),
    .g_pkt_to_msg_i(gnt),
    .out_link_o(out_link),
    .out_len_o(out_len),
    .pkt_count_o(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_acc();
    pkt_t e;
    e.len = 3'(acc_n);
    e.dat = acc;
    sbq.push_back(e);
  endtask

  task automatic clr_cnt();
    ncred = 0;
    nerr  = 0;
    nfree = 0;
  endtask

  // One clock of stimulus; a grant seen while a packet is offered pops the scoreboard
  task automatic step(input logic v, input logic [1:0] t, input logic [29:0] pl, input logic g);
    pkt_t e;
    @(negedge clk);
    if (g && r_pkt) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("out_len", 32'(out_len), 32'(e.len));
        for (int i = 0; i < 4; i++) begin
          if (i < int'(e.len)) chk("out_flit", out_link[i*32 +: 32], e.dat[i*32 +: 32]);
        end
      end
    end
    is_valid = v;
    in_link  = {t, pl};
    gnt      = g;
    if (v) begin
      if (t == HD || t == HT) begin
        acc_n = 0;
        acc   = '0;
      end
      if (acc_n < 4) begin
        acc[acc_n*32 +: 32] = {t, pl};
        acc_n++;
      end
    end
    @(posedge clk);
    #1;
    ncred    += int'(credit);
    nerr     += int'(err);
    nfree    += int'(free);
    last_err  = err;
    last_free = free;
    is_valid  = 1'b0;
    gnt       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    is_valid = 1'b0;
    in_link  = '0;
    gnt      = 1'b0;
    acc      = '0;
    acc_n    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_r", 32'(r_pkt), 32'd0);
    chk("rst_len", 32'(out_len), 32'd0);
    chk("rst_pulses", {29'd0, credit, free, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a packet
    step(1'b1, HD, 30'h101, 1'b0);
    step(1'b1, BD, 30'h102, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_count", 32'(pkt_count), 32'd0);
    chk("midrst_r", 32'(r_pkt), 32'd0);
    step(1'b1, BD, 30'h103, 1'b0);
    chk("midrst_body_err", 32'(last_err), 32'd1);

    // Two packets with no grant, then a third is refused
    clr_cnt();
    step(1'b1, HD, 30'h201, 1'b0);
    step(1'b1, BD, 30'h202, 1'b0);
    step(1'b1, TL, 30'h203, 1'b0);
    push_acc();
    step(1'b1, HT, 30'h204, 1'b0);
    push_acc();
    step(1'b0, HD, 30'h0, 1'b0);
    chk("two_count", 32'(pkt_count), 32'd2);
    chk("two_len", 32'(out_len), 32'd3);
    chk("two_credits", 32'(ncred), 32'd4);
    chk("two_noerr", 32'(nerr), 32'd0);
    step(1'b1, HT, 30'h205, 1'b0);
    chk("full_err", 32'(last_err), 32'd1);
    step(1'b0, HD, 30'h0, 1'b0);
    chk("full_count", 32'(pkt_count), 32'd2);
    clr_cnt();
    step(1'b0, HD, 30'h0, 1'b1);
    step(1'b0, HD, 30'h0, 1'b1);
    step(1'b0, HD, 30'h0, 1'b0);
    chk("drain_free", 32'(nfree), 32'd2);
    chk("drain_count", 32'(pkt_count), 32'd0);

    // Grant on the same cycle a TAIL closes the next slot
    clr_cnt();
    step(1'b1, HT, 30'h301, 1'b0);
    push_acc();
    step(1'b1, HD, 30'h302, 1'b0);
    step(1'b1, TL, 30'h303, 1'b1);
    push_acc();
    chk("cg_count", 32'(pkt_count), 32'd1);
    chk("cg_free", 32'(last_free), 32'd1);
    chk("cg_len", 32'(out_len), 32'd2);
    step(1'b0, HD, 30'h0, 1'b1);
    step(1'b0, HD, 30'h0, 1'b0);
    chk("cg_empty", 32'(r_pkt), 32'd0);

    // Overlong packet: the body that leaves no room for a TAIL is refused
    clr_cnt();
    step(1'b1, HD, 30'h401, 1'b0);
    step(1'b1, BD, 30'h402, 1'b0);
    step(1'b1, BD, 30'h403, 1'b0);
    chk("long_noerr", 32'(nerr), 32'd0);
    step(1'b1, BD, 30'h404, 1'b0);
    chk("long_err", 32'(last_err), 32'd1);
    step(1'b1, BD, 30'h405, 1'b0);
    chk("long_credits", 32'(ncred), 32'd5);
    step(1'b1, TL, 30'h406, 1'b0);
    chk("long_err_total", 32'(nerr), 32'd1);
    chk("long_count", 32'(pkt_count), 32'd0);
    step(1'b1, HT, 30'h407, 1'b0);
    push_acc();
    step(1'b0, HD, 30'h0, 1'b0);
    chk("long_idle_accept", 32'(pkt_count), 32'd1);
    step(1'b0, HD, 30'h0, 1'b1);

    // Ring wrap with interleaved grants
    clr_cnt();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, HT, 30'(32'h500 + k), 1'b0);
      push_acc();
      step(1'b0, HD, 30'h0, 1'b1);
    end
    step(1'b0, HD, 30'h0, 1'b0);
    chk("wrap_noerr", 32'(nerr), 32'd0);
    chk("wrap_free", 32'(nfree), 32'd5);
    chk("wrap_count", 32'(pkt_count), 32'd0);
    chk("sb_left", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
